// File: rtl/colorizer_palette_ctrl_if.sv
// CPU-side palette write and commit bus for the colorizer palette controller.
// The master drives the requests and the slave (the controller) returns the acks.
interface colorizer_palette_ctrl_if;
  logic       wr_req;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       commit_req;
  logic       commit_pending;
  logic       commit_done;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_data,
    output commit_req,
    input  wr_ack,
    input  commit_pending,
    input  commit_done
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    input  commit_req,
    output wr_ack,
    output commit_pending,
    output commit_done
  );
endinterface

// File: rtl/colorizer_palette_ctrl.sv
// Palette controller: the CPU writes a shadow palette, which is copied to the active
// palette at vertical-blank entry; icon colour 3 blinks on a frame-counted period.
module colorizer_palette_ctrl #(
  parameter int         BLINK_FRAMES = 30,
  parameter logic [7:0] BLINK_COLOR  = 8'h00
) (
  input  logic                     clock,
  input  logic                     rst,
  colorizer_palette_ctrl_if.slave  bus,
  input  logic                     vblank,
  input  logic                     blink_en,
  output logic [31:0]              wall_pal,
  output logic [23:0]              icon_pal
);

  localparam logic [31:0] WALL_DEFAULT = 32'h92E000FF;
  localparam logic [23:0] ICON_DEFAULT = 24'hE31F80;
  localparam logic [7:0]  LAST_FRAME   = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_DROP
  } wr_state_t;

  wr_state_t   wr_state;
  logic [31:0] shadow_wall;
  logic [23:0] shadow_icon;
  logic [7:0]  active_icon3;
  logic        vblank_q;
  logic [7:0]  frame_cnt;
  logic        blink_phase;

  logic        vblank_rise;
  logic        do_commit;
  logic [7:0]  frame_cnt_next;
  logic        blink_phase_next;
  logic [7:0]  icon3_next;

  // A commit request arriving on the vblank edge itself is honoured at that edge.
  always_comb begin
    vblank_rise = vblank & ~vblank_q;
    do_commit   = vblank_rise & (bus.commit_pending | bus.commit_req);
    icon3_next  = do_commit ? shadow_icon[23:16] : active_icon3;

    frame_cnt_next   = frame_cnt;
    blink_phase_next = blink_phase;
    if (!blink_en) begin
      frame_cnt_next   = 8'd0;
      blink_phase_next = 1'b0;
    end else if (vblank_rise) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt_next   = 8'd0;
        blink_phase_next = ~blink_phase;
      end else begin
        frame_cnt_next = frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_state    <= IDLE;
      bus.wr_ack  <= 1'b0;
      shadow_wall <= WALL_DEFAULT;
      shadow_icon <= ICON_DEFAULT;
    end else begin
      case (wr_state)
        IDLE: begin
          if (bus.wr_req) begin
            case (bus.wr_addr)
              3'd0:    shadow_wall[7:0]   <= bus.wr_data;
              3'd1:    shadow_wall[15:8]  <= bus.wr_data;
              3'd2:    shadow_wall[23:16] <= bus.wr_data;
              3'd3:    shadow_wall[31:24] <= bus.wr_data;
              3'd5:    shadow_icon[7:0]   <= bus.wr_data;
              3'd6:    shadow_icon[15:8]  <= bus.wr_data;
              3'd7:    shadow_icon[23:16] <= bus.wr_data;
              default: ;
            endcase
            bus.wr_ack <= 1'b1;
            wr_state   <= ACK;
          end
        end
        ACK: begin
          bus.wr_ack <= 1'b0;
          wr_state   <= WAIT_DROP;
        end
        WAIT_DROP: begin
          // A held request must drop before another write is accepted.
          if (!bus.wr_req) begin
            wr_state <= IDLE;
          end
        end
        default: begin
          bus.wr_ack <= 1'b0;
          wr_state   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      vblank_q           <= 1'b0;
      bus.commit_pending <= 1'b0;
      bus.commit_done    <= 1'b0;
      wall_pal           <= WALL_DEFAULT;
      icon_pal           <= ICON_DEFAULT;
      active_icon3       <= ICON_DEFAULT[23:16];
      frame_cnt          <= 8'd0;
      blink_phase        <= 1'b0;
    end else begin
      vblank_q    <= vblank;
      frame_cnt   <= frame_cnt_next;
      blink_phase <= blink_phase_next;
      if (do_commit) begin
        wall_pal           <= shadow_wall;
        icon_pal[15:0]     <= shadow_icon[15:0];
        active_icon3       <= shadow_icon[23:16];
        bus.commit_pending <= 1'b0;
        bus.commit_done    <= 1'b1;
      end else begin
        bus.commit_done <= 1'b0;
        if (bus.commit_req) begin
          bus.commit_pending <= 1'b1;
        end
      end
      // Icon 3 output reflects the post-edge phase so a cleared blink shows at once.
      icon_pal[23:16] <= blink_phase_next ? BLINK_COLOR : icon3_next;
    end
  end

endmodule

// File: tb/tb_colorizer_palette_ctrl.sv
// Self-checking bench for colorizer_palette_ctrl: directed scenarios plus random
// traffic, compared every cycle against a behavioural palette model.
module tb_colorizer_palette_ctrl;

  localparam int         BF = 2;
  localparam logic [7:0] BC = 8'h00;

  logic        clock;
  logic        rst;
  logic        vblank;
  logic        blink_en;
  logic [31:0] wall_pal;
  logic [23:0] icon_pal;

  colorizer_palette_ctrl_if bus ();

  colorizer_palette_ctrl #(
    .BLINK_FRAMES(BF),
    .BLINK_COLOR (BC)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .bus     (bus),
    .vblank  (vblank),
    .blink_en(blink_en),
    .wall_pal(wall_pal),
    .icon_pal(icon_pal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: palettes as byte arrays indexed by write address.
  logic [7:0] m_shadow [8];
  logic [7:0] m_active [8];
  int         m_wstate;
  bit         m_ack, m_pend, m_done, m_vb_prev, m_rise;
  int         m_edges;

  task automatic model_reset();
    m_shadow[0] = 8'hFF; m_shadow[1] = 8'h00; m_shadow[2] = 8'hE0; m_shadow[3] = 8'h92;
    m_shadow[4] = 8'h00; m_shadow[5] = 8'h80; m_shadow[6] = 8'h1F; m_shadow[7] = 8'hE3;
    m_active = m_shadow;
    m_wstate = 0;
    m_ack = 0; m_pend = 0; m_done = 0; m_vb_prev = 0;
    m_edges = 0;
  endtask

  task automatic model_step();
    m_rise    = vblank && !m_vb_prev;
    m_vb_prev = vblank;
    if (m_rise && (m_pend || bus.commit_req)) begin
      m_active = m_shadow;
      m_pend   = 0;
      m_done   = 1;
    end else begin
      m_done = 0;
      if (bus.commit_req) m_pend = 1;
    end
    if (!blink_en) m_edges = 0;
    else if (m_rise) m_edges++;
    m_ack = 0;
    if (m_wstate == 0) begin
      if (bus.wr_req) begin
        if (bus.wr_addr != 3'd4) m_shadow[bus.wr_addr] = bus.wr_data;
        m_ack    = 1;
        m_wstate = 1;
      end
    end else if (m_wstate == 1) begin
      m_wstate = 2;
    end else if (!bus.wr_req) begin
      m_wstate = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    logic [23:0] exp_icon;
    forever begin
      @(negedge clock);
      exp_icon = {(((m_edges / BF) % 2) == 1) ? BC : m_active[7], m_active[6], m_active[5]};
      check_output("model_wall", wall_pal, {m_active[3], m_active[2], m_active[1], m_active[0]});
      check_output("model_icon", {8'h00, icon_pal}, {8'h00, exp_icon});
      check_output("model_ack", {31'd0, bus.wr_ack}, {31'd0, m_ack});
      check_output("model_pending", {31'd0, bus.commit_pending}, {31'd0, m_pend});
      check_output("model_done", {31'd0, bus.commit_done}, {31'd0, m_done});
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  // Starts and ends on a falling edge; returns the ack count and the cycle of the first ack.
  task automatic apply_write(input logic [2:0] addr, input logic [7:0] data, input int hold,
                             output int acks, output int first);
    acks  = 0;
    first = 0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    for (int i = 1; i <= hold + 3; i++) begin
      tick();
      if (bus.wr_ack) begin
        acks++;
        if (first == 0) first = i;
      end
      if (i == hold) bus.wr_req = 1'b0;
    end
  endtask

  task automatic apply_commit();
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
  endtask

  logic [7:0] blink_seq [6] = '{8'hE3, 8'h00, 8'h00, 8'hE3, 8'hE3, 8'h00};

  initial begin
    int acks, first;
    rst = 1'b0;
    vblank = 1'b0;
    blink_en = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_data = 8'h00;
    bus.commit_req = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_output("reset_wall", wall_pal, 32'h92E000FF);
    check_output("reset_icon", {8'h00, icon_pal}, 32'h00E31F80);
    check_output("reset_ack", {31'd0, bus.wr_ack}, 32'd0);
    check_output("reset_pending", {31'd0, bus.commit_pending}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Write then commit with a long wait before vblank.
    apply_write(3'd0, 8'h1C, 1, acks, first);
    check_output("wc_ack_latency", first, 1);
    check_output("wc_ack_count", acks, 1);
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    check_output("wc_pending_set", {31'd0, bus.commit_pending}, 32'd1);
    repeat (50) tick();
    check_output("wc_wall0_before", {24'd0, wall_pal[7:0]}, 32'hFF);
    vblank = 1'b1;
    tick();
    check_output("wc_wall0_after", {24'd0, wall_pal[7:0]}, 32'h1C);
    check_output("wc_done", {31'd0, bus.commit_done}, 32'd1);
    check_output("wc_pending_clr", {31'd0, bus.commit_pending}, 32'd0);
    tick();
    check_output("wc_done_single", {31'd0, bus.commit_done}, 32'd0);
    vblank = 1'b0;
    tick();

    // Held request produces exactly one acknowledge.
    apply_write(3'd6, 8'h55, 10, acks, first);
    check_output("hold_ack_count", acks, 1);
    apply_write(3'd5, 8'h33, 1, acks, first);
    check_output("hold_second_ack", acks, 1);
    apply_commit();
    check_output("hold_icon2", {24'd0, icon_pal[15:8]}, 32'h55);

    // Write, commit request and vblank edge all in the same cycle.
    bus.wr_req = 1'b1;
    bus.wr_addr = 3'd7;
    bus.wr_data = 8'hAA;
    bus.commit_req = 1'b1;
    vblank = 1'b1;
    tick();
    check_output("sim_done", {31'd0, bus.commit_done}, 32'd1);
    check_output("sim_icon3_old", {24'd0, icon_pal[23:16]}, 32'hE3);
    bus.wr_req = 1'b0;
    bus.commit_req = 1'b0;
    tick();
    check_output("sim_no_pending", {31'd0, bus.commit_pending}, 32'd0);
    vblank = 1'b0;
    repeat (2) tick();
    apply_commit();
    check_output("sim_icon3_new", {24'd0, icon_pal[23:16]}, 32'hAA);

    // Reserved address is acknowledged but changes nothing.
    apply_write(3'd4, 8'hFF, 1, acks, first);
    check_output("rsv_ack", acks, 1);
    apply_commit();
    check_output("rsv_wall", wall_pal, 32'h92E0001C);
    check_output("rsv_icon", {8'h00, icon_pal}, 32'h00AA5533);

    // Blink sequence with icon 3 restored to its default.
    apply_write(3'd7, 8'hE3, 1, acks, first);
    apply_commit();
    blink_en = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      vblank = 1'b1;
      tick();
      check_output($sformatf("blink_edge%0d", k), {24'd0, icon_pal[23:16]}, {24'd0, blink_seq[k]});
      vblank = 1'b0;
      repeat (2) tick();
    end
    blink_en = 1'b0;
    tick();
    check_output("blink_off", {24'd0, icon_pal[23:16]}, 32'hE3);

    // Random traffic checked by the model on every cycle.
    for (int c = 0; c < 800; c++) begin
      bus.wr_req = ($urandom_range(0, 3) != 0);
      bus.wr_addr = 3'($urandom_range(0, 7));
      bus.wr_data = 8'($urandom_range(0, 255));
      bus.commit_req = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 5) == 0) vblank = ~vblank;
      if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
      tick();
    end
    bus.wr_req = 1'b0;
    bus.commit_req = 1'b0;
    vblank = 1'b0;
    blink_en = 1'b0;
    repeat (4) tick();

    // Reset asserted while acknowledging with a commit pending.
    bus.wr_req = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 8'h11;
    bus.commit_req = 1'b1;
    tick();
    check_output("mid_pre_ack", {31'd0, bus.wr_ack}, 32'd1);
    check_output("mid_pre_pending", {31'd0, bus.commit_pending}, 32'd1);
    bus.commit_req = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_output("mid_ack", {31'd0, bus.wr_ack}, 32'd0);
    check_output("mid_pending", {31'd0, bus.commit_pending}, 32'd0);
    check_output("mid_wall", wall_pal, 32'h92E000FF);
    check_output("mid_icon", {8'h00, icon_pal}, 32'h00E31F80);
    bus.wr_req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/colorizer_palette_ctrl.md
Name: colorizer_palette_ctrl

Overview:
- Programmable palette controller for the Rojobot world video pipeline.
- Holds a shadow palette that the CPU-side interface writes through a req/ack handshake.
- Transfers the shadow palette to the active palette atomically on the next vertical-blank entry, so a frame never shows a half-updated palette.
- Drives the active wall and icon colours into the colorizer datapath and adds a frame-counted blink on icon colour 3.

Parameters:
- BLINK_FRAMES, 30, frames per blink half-period (legal range 1..255).
- BLINK_COLOR, 8'h00, colour substituted for icon colour 3 during the blink-on phase.

Ports:
- clock  in  1  25 MHz pixel clock
- rst  in  1  asynchronous active-high reset
- wr_req  in  1  write request, level; held until wr_ack is seen
- wr_addr  in  3  palette index: 0-3 wall colours 0-3; 4 reserved (icon 0, transparent); 5-7 icon colours 1-3
- wr_data  in  8  colour in RRR_GGG_BB format
- wr_ack  out  1  single-cycle write acknowledge
- commit_req  in  1  single-cycle pulse requesting shadow-to-active transfer
- commit_pending  out  1  high while a commit waits for vblank
- commit_done  out  1  single-cycle pulse when the active palette is updated
- vblank  in  1  high during vertical blanking
- blink_en  in  1  enables blinking of icon colour 3
- wall_pal  out  32  active wall colours; [7:0]=wall0 … [31:24]=wall3
- icon_pal  out  24  active icon colours; [7:0]=icon1, [15:8]=icon2, [23:16]=icon3 (after blink substitution)

Behaviour:
- Reset (async, rst=1):
  - Shadow and active palettes load the defaults: wall0=FF, wall1=00, wall2=E0, wall3=92, icon1=80, icon2=1F, icon3=E3.
  - wall_pal=32'h92E000FF, icon_pal=24'hE31F80.
  - wr_ack=0, commit_pending=0, commit_done=0, frame counter=0, blink phase=0, write FSM=IDLE, vblank edge register=0.
- All other state updates on the rising edge of clock.
- Write FSM: IDLE -> ACK -> WAIT_DROP -> IDLE.
  - IDLE: wr_req=1 sampled -> shadow[wr_addr] <= wr_data; go to ACK.
  - ACK: wr_ack=1 for exactly this one cycle; go to WAIT_DROP.
  - WAIT_DROP: stay until wr_req=0, then go to IDLE.
  - Write-to-ack latency: 1 cycle. Maximum throughput: one write per 3 cycles.
  - wr_addr=4: acknowledged normally; no register changes.
- vblank edge: vblank is registered once; the rising edge is current vblank=1 and registered vblank=0.
- Commit:
  - commit_req=1 sets commit_pending on the next edge.
  - On a vblank rising edge with (commit_pending | commit_req): active <= shadow, commit_pending <= 0, commit_done <= 1 for one cycle.
  - commit_req in the same cycle as the vblank rising edge is applied at that edge; commit_pending never asserts in that case.
  - Repeated commit_req while already pending: no additional effect.
  - Shadow write and commit in the same cycle: active receives the pre-write shadow value; the new value waits for the next commit.
- Blink:
  - blink_en=0: frame counter and blink phase forced to 0.
  - blink_en=1: on each vblank rising edge the counter increments.
  - When the counter reaches BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - icon_pal[23:16] = BLINK_COLOR when phase=1, otherwise active icon3.
  - BLINK_FRAMES=1 toggles the phase every frame.
- Outputs: wall_pal and icon_pal are registered (change only on clock edges) and are never combinational from inputs.
- Active palette outputs change only at vblank edges, by commit or blink phase change. Exception: the blink phase clears on the clock edge after blink_en falls.

Test Plan:
- Reset mid-operation: assert rst during the ACK state with commit_pending=1 -> wr_ack=0, commit_pending=0, wall_pal=92E000FF, icon_pal=E31F80 immediately, without waiting for a clock edge.
- Write then commit: write addr 0 = 1C, pulse commit_req, assert vblank 50 cycles later -> wr_ack is 1 cycle after wr_req; wall_pal[7:0] stays FF until the vblank edge; then wall_pal[7:0]=1C, commit_done pulses once, and commit_pending drops in the same cycle.
- Handshake hold: keep wr_req high for 10 cycles with addr 6, data 55 -> exactly one wr_ack; a second write occurs only after wr_req drops and rises again; icon_pal[15:8]=55 after commit.
- Simultaneous events: commit_req and vblank rise in the same cycle as a write to addr 7 = AA -> commit_done pulses; icon3 keeps its pre-write value; the next commit yields AA.
- Reserved address: write addr 4 = FF, then commit -> wr_ack pulses; wall_pal and icon_pal are unchanged from their pre-write values.
- Blink with BLINK_FRAMES=2, blink_en=1, 6 vblank pulses -> icon_pal[23:16] sequence after each edge: E3, 00, 00, E3, E3, 00. Dropping blink_en gives E3 on the next cycle.
